main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/main_fsm_if.sv | 29 ++
 rtl/main_fsm.sv | 143 ++++++++++++++
 tb/tb_main_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller and the ALU decoder that sits beside it:
// state enum, opcodes, datapath mux selects and ALU operation classes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Unsupported opcodes map to FETCH so DECODE simply abandons the instruction.
    function automatic state_t decode_target(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: decode_target = MEMADR;
            OP_RTYPE:     decode_target = EXECR;
            OP_ITYPE:     decode_target = EXECI;
            OP_BEQ:       decode_target = BEQ;
            OP_JAL:       decode_target = JAL;
            default:      decode_target = FETCH;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        op_supported = (op == OP_LW)    || (op == OP_SW)    || (op == OP_RTYPE) ||
                       (op == OP_ITYPE) || (op == OP_BEQ)   || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Controller <-> datapath bundle: instruction/status inputs and the control word.
// master is the controller side, slave is the datapath side.
interface main_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RISC-V style control FSM: one state register, one next-state block, one output block.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 and load IR when memory is ready
// DECODE   | read registers, precompute branch target OldPC + imm, dispatch on op
// MEMADR   | compute load/store address rs1 + imm
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | write loaded data to the register file
// MEMWRITE | write data memory at ALUOut, wait for mem_ready
// EXECR    | R-type ALU operation rs1 op rs2
// EXECI    | I-type ALU operation rs1 op imm
// ALUWB    | write ALUOut to the register file
// BEQ      | compare rs1 - rs2, take precomputed target when zero
// JAL      | PC <= target, compute return address OldPC + 4
module main_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    main_fsm_if.master bus
);

    state_t     r_state;
    state_t     w_next_state;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:    w_next_state = bus.mem_ready ? DECODE : FETCH;
            DECODE:   w_next_state = decode_target(bus.op);
            MEMADR:   w_next_state = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next_state = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    w_next_state = FETCH;
            MEMWRITE: w_next_state = bus.mem_ready ? FETCH : MEMWRITE;
            EXECR:    w_next_state = ALUWB;
            EXECI:    w_next_state = ALUWB;
            ALUWB:    w_next_state = FETCH;
            BEQ:      w_next_state = FETCH;
            JAL:      w_next_state = ALUWB;
            default:  w_next_state = FETCH;
        endcase
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            FETCH: begin
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = bus.mem_ready;
                w_pc_update  = bus.mem_ready;
            end
            DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                w_illegal   = !op_supported(bus.op);
            end
            MEMADR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                w_adr_src = 1'b1;
            end
            MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
            end
            MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            EXECR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_RS2;
                w_alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
                w_alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
            end
            BEQ: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_RS2;
                w_alu_op    = ALUOP_SUB;
                w_branch    = 1'b1;
            end
            JAL: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are forced low while reset is held so a reset landing mid-store cannot write memory.
    assign bus.pc_write   = rst_n & (w_pc_update | (w_branch & bus.zero));
    assign bus.ir_write   = rst_n & w_ir_write;
    assign bus.mem_write  = rst_n & w_mem_write;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.illegal    = rst_n & w_illegal;
    assign bus.adr_src    = w_adr_src;
    assign bus.result_src = w_result_src;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: each cycle's expected state and control word is queued, then
// popped and checked at the falling edge.
module tb_main_fsm;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    main_fsm_if bus();

    main_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        state_t      st;
        logic [13:0] vec;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal}
    function automatic logic [13:0] ov(input bit pc, input bit adr, input bit mw, input bit irw,
                                       input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] aop,
                                       input bit rw, input bit ill);
        return {pc, adr, mw, irw, rs, a, b, aop, rw, ill};
    endfunction

    function automatic logic [13:0] observed();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.illegal};
    endfunction

    function automatic logic [13:0] e_fetch(input bit go);
        return ov(go, 0, 0, go, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    endfunction
    function automatic logic [13:0] e_decode(input bit ill);
        return ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, ill);
    endfunction
    function automatic logic [13:0] e_memwrite(input bit mw);
        return ov(0, 1, mw, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [13:0] e_beq(input bit z);
        return ov(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    endfunction

    logic [13:0] e_memadr, e_memread, e_memwb, e_execr, e_execi, e_aluwb, e_jal;
    initial begin
        e_memadr  = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
        e_memread = ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        e_memwb   = ov(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
        e_execr   = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
        e_execi   = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
        e_aluwb   = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        e_jal     = ov(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
    end

    task automatic push(input state_t st, input logic [13:0] v, input string tag);
        exp_t e;
        e.st  = st;
        e.vec = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed no expectation, expected one queued");
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (dut.r_state === e.st) else begin
                miscompares++;
                $error("FAIL %s state: observed %0d expected %0d", e.tag, dut.r_state, e.st);
            end
            vectors++;
            assert (observed() === e.vec) else begin
                miscompares++;
                $error("FAIL %s ctrl: observed %b expected %b", e.tag, observed(), e.vec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input state_t st, input logic [13:0] v, input string tag);
        push(st, v, tag);
        check_cycle();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.op        = OP_RTYPE;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset held with mem_ready=1: FETCH outputs but no enables
        step(FETCH, e_fetch(0), "rst_a");
        step(FETCH, e_fetch(0), "rst_b");

        // R-type
        rst_n = 1'b1;
        step(FETCH,  e_fetch(1),  "r_fetch");
        step(DECODE, e_decode(0), "r_decode");
        step(EXECR,  e_execr,     "r_execr");
        step(ALUWB,  e_aluwb,     "r_aluwb");

        // I-type
        bus.op = OP_ITYPE;
        step(FETCH,  e_fetch(1),  "i_fetch");
        step(DECODE, e_decode(0), "i_decode");
        step(EXECI,  e_execi,     "i_execi");
        step(ALUWB,  e_aluwb,     "i_aluwb");

        // illegal opcode
        bus.op = 7'b1111111;
        step(FETCH,  e_fetch(1),  "ill_fetch");
        step(DECODE, e_decode(1), "ill_decode");

        // lw with a fetch stall and three wait cycles in MEMREAD
        bus.op        = OP_LW;
        bus.mem_ready = 1'b0;
        step(FETCH,   e_fetch(0), "lw_fetch_stall");
        bus.mem_ready = 1'b1;
        step(FETCH,   e_fetch(1), "lw_fetch");
        step(DECODE,  e_decode(0), "lw_decode");
        step(MEMADR,  e_memadr,   "lw_memadr");
        bus.mem_ready = 1'b0;
        step(MEMREAD, e_memread,  "lw_wait1");
        step(MEMREAD, e_memread,  "lw_wait2");
        step(MEMREAD, e_memread,  "lw_wait3");
        bus.mem_ready = 1'b1;
        step(MEMREAD, e_memread,  "lw_read");
        step(MEMWB,   e_memwb,    "lw_memwb");

        // sw, memory ready immediately
        bus.op = OP_SW;
        step(FETCH,    e_fetch(1),    "sw_fetch");
        step(DECODE,   e_decode(0),   "sw_decode");
        step(MEMADR,   e_memadr,      "sw_memadr");
        step(MEMWRITE, e_memwrite(1), "sw_write");

        // beq taken then not taken; zero=1 in DECODE must not move the PC
        bus.op   = OP_BEQ;
        bus.zero = 1'b1;
        step(FETCH,  e_fetch(1),  "beq1_fetch");
        step(DECODE, e_decode(0), "beq1_decode");
        step(BEQ,    e_beq(1),    "beq_taken");
        bus.zero = 1'b0;
        step(FETCH,  e_fetch(1),  "beq0_fetch");
        step(DECODE, e_decode(0), "beq0_decode");
        step(BEQ,    e_beq(0),    "beq_not_taken");

        // jal
        bus.op = OP_JAL;
        step(FETCH,  e_fetch(1),  "jal_fetch");
        step(DECODE, e_decode(0), "jal_decode");
        step(JAL,    e_jal,       "jal_jal");
        step(ALUWB,  e_aluwb,     "jal_aluwb");

        // reset while MEMWRITE is waiting
        bus.op = OP_SW;
        step(FETCH,    e_fetch(1),    "swr_fetch");
        step(DECODE,   e_decode(0),   "swr_decode");
        step(MEMADR,   e_memadr,      "swr_memadr");
        bus.mem_ready = 1'b0;
        step(MEMWRITE, e_memwrite(1), "swr_wait");
        rst_n = 1'b0;
        step(MEMWRITE, e_memwrite(0), "swr_reset");
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;
        step(FETCH,    e_fetch(1),    "swr_after_reset");

        // reset while MEMREAD is waiting
        bus.op = OP_LW;
        step(DECODE,  e_decode(0), "lwr_decode");
        step(MEMADR,  e_memadr,    "lwr_memadr");
        bus.mem_ready = 1'b0;
        step(MEMREAD, e_memread,   "lwr_wait");
        rst_n = 1'b0;
        step(MEMREAD, e_memread,   "lwr_reset");
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;
        step(FETCH,   e_fetch(1),  "lwr_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
